hex_display_mux: RTL
====================

# hex_display_mux

Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It is the scanning successor to the single-digit hex-to-segment decoder: it latches an N×4-bit hex value and drives one digit per refresh slot through a shared segment bus. It also handles per-digit decimal points, optional leading-zero blanking, and a tear-free frame-boundary update. It sits between the datapath/status registers and the board display pins.

## Interface
Parameters:
- `N_DIGITS`, 4: number of digits (≥1); digit 0 is least significant, rightmost.
- `REFRESH_DIV`, 50000: clock cycles per digit slot (≥2).
- `SEG_ACTIVE_LOW`, 1: 1 = segment/dp outputs active-low.
- `AN_ACTIVE_LOW`, 1: 1 = digit-select outputs active-low.

Ports:
- `clk`  in  1: single clock. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `load`  in  1: one-cycle strobe; captures `value`/`dp_in` into the shadow register.
- `value`  in  4*N_DIGITS: hex nibbles; nibble i = digit i.
- `dp_in`  in  N_DIGITS: decimal point per digit, 1 = lit.
- `blank_lz`  in  1: level; 1 = blank leading zeros.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, polarity per `SEG_ACTIVE_LOW`.
- `dp`  out  1: decimal point of the active digit.
- `an`  out  N_DIGITS: digit select, one-hot active, polarity per `AN_ACTIVE_LOW`.
- `pending`  out  1: shadow holds data not yet displayed.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when `pcnt==REFRESH_DIV-1`.
- Digit index `idx` (width $clog2(N_DIGITS), min 1) advances on `tick` and wraps from N_DIGITS-1 to 0.
- Frame boundary: `tick && idx==N_DIGITS-1`.
- `load` writes the shadow register (value + dp) and sets `pending`.
- At a frame boundary with `pending`=1, the display register takes the shadow. `pending` clears unless `load` is asserted the same cycle. In that case the display register takes the old shadow, the shadow takes the new value, and `pending` stays 1.
- Display register changes only at frame boundaries, so a frame never mixes two values.
- Decode is active-high internally: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, B→7C, C→39, D→5E, E→79, F→71. The output is inverted when `SEG_ACTIVE_LOW`.
- Leading-zero blanking (`blank_lz`=1): digit i>0 is blanked if nibbles i..N_DIGITS-1 of the display register are all zero. Digit 0 is never blanked.
- A blanked digit or reset state drives `an` all inactive, `seg` all off and `dp` off.
- `blank_lz` is sampled live, not shadowed.

## Timing
- Reset values:
  - `pcnt`=0, `idx`=0, shadow=0, display=0, `pending`=0.
  - `seg`=all off (7'h7F when active-low), `dp` off, `an` all inactive.
- `seg`/`dp`/`an` are registered. They reflect `idx` and display register contents one cycle after those change.
- First cycle after reset deasserts: outputs still off. From the second cycle, digit 0 of value 0 is shown.
- `load` to `pending`=1: 1 cycle.
- Latency to display: ≤ N_DIGITS*REFRESH_DIV+1 cycles after `load`.
- Reset mid-scan aborts the frame. All state, including a pending shadow, is cleared in the same edge.
- `load` during reset is ignored.

## Structure
- Package `display_pkg`:
  - `seg_t` (logic [6:0]).
  - `localparam seg_t HEX_SEG[16]` pattern table.
  - `SEG_OFF` constant.
- Sub-module `seg7_hex_lut`: combinational nibble→`seg_t` (active-high), one instance on the muxed nibble.
- Top holds the prescaler, index counter, shadow/display registers, blanking logic and output registers.

## Test plan
All scenarios use `N_DIGITS`=4, `REFRESH_DIV`=4, both polarities active-low.
- Reset held 3 cycles → `an`=4'b1111, `seg`=7'h7F, `dp`=1, `pending`=0. Released → digit 0 shows '0' (`seg`=7'h40, `an`=4'b1110) from the 2nd cycle.
- `load` with `value`=16'h12AF, `dp_in`=4'b0100 → `pending`=1 next cycle. After the next frame boundary, `pending`=0 and the scan shows:
  - F: `seg`=7'h0E, `an`=1110.
  - A: `seg`=7'h08, `an`=1101.
  - 2: `seg`=7'h24, `an`=1011, `dp`=0.
  - 1: `seg`=7'h79, `an`=0111.
  - Each digit lasts 4 cycles, then wraps.
- `value`=16'h0005 with `blank_lz`=1 → `an`=1110 with `seg`=7'h12 in slot 0. Slots 1-3 have `an`=1111. With `value`=0, digit 0 still shows '0'.
- `load` asserted exactly on a frame-boundary cycle while pending → display takes the old shadow, the new value remains shadowed, `pending` stays 1, and the new value is shown one frame later.
- Reset asserted mid-frame with `pending`=1 → next cycle all outputs off, `pending`=0, and the scan restarts at digit 0 showing 0.
- Two `load`s within one frame (16'h1111 then 16'h2222) → only 16'h2222 is ever displayed, with no intermediate mix.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment types and hex glyph table for the display mux
//
// Purpose: segment bus type, active-high hex glyph table and the blank glyph.
// Ports:   none (package).

package display_pkg;

   // Segment order is {g,f,e,d,c,b,a}. Bits are active-high here.
   // Pin polarity is applied only at the output registers.
   typedef logic [6:0] seg_t;

   localparam seg_t HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A B
      7'h39, 7'h5E, 7'h79, 7'h71    // C D E F
   };

   localparam seg_t SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_hex_lut.sv
// rtl/seg7_hex_lut.sv - combinational hex nibble to seven-segment glyph
//
// Purpose: maps one 4-bit hex nibble to its active-high segment pattern.
// Ports:
//   nibble_i  in  4  hex digit to decode
//   seg_o     out 7  segments {g,f,e,d,c,b,a}, active-high

module seg7_hex_lut
   import display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/hex_display_mux.sv
// rtl/hex_display_mux.sv - scanning N-digit seven-segment driver with tear-free update
//
// Purpose: latches an N-digit hex value into a shadow register. The display register
//          copies the shadow only at frame boundaries. Each refresh slot drives one
//          digit, with optional leading-zero blanking. All pin outputs are registered.
// Ports:
//   clk       in  1            clock
//   reset     in  1            synchronous, active-high
//   load      in  1            strobe: capture value/dp_in into the shadow register
//   value     in  4*N_DIGITS   hex nibbles, nibble i = digit i
//   dp_in     in  N_DIGITS     per-digit decimal point, 1 = lit
//   blank_lz  in  1            live level: blank leading zeros
//   seg       out 7            segments {g,f,e,d,c,b,a}, pin polarity
//   dp        out 1            decimal point of the active digit, pin polarity
//   an        out N_DIGITS     one-hot digit select, pin polarity
//   pending   out 1            shadow holds data not yet displayed

module hex_display_mux
   import display_pkg::*;
#(
   parameter int N_DIGITS       = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic                  pending
);

   localparam int VAL_W  = 4 * N_DIGITS;
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int PCNT_W = $clog2(REFRESH_DIV);

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

   // Polarity masks. Each one is XORed onto an active-high value to produce the pin value.
   localparam logic                SEG_INV     = (SEG_ACTIVE_LOW != 0);
   localparam seg_t                SEG_MASK    = {7{SEG_INV}};
   localparam logic [N_DIGITS-1:0] AN_MASK     = {N_DIGITS{AN_ACTIVE_LOW != 0}};
   localparam seg_t                SEG_PIN_OFF = SEG_OFF ^ SEG_MASK;

   // ---------------------------------------------------------------- state
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [VAL_W-1:0]    shadow_val_q, shadow_val_d;
   logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
   logic [VAL_W-1:0]    disp_val_q, disp_val_d;
   logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic                pending_q, pending_d;
   seg_t                seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [N_DIGITS-1:0] an_q, an_d;

   logic tick;
   logic frame_end;

   // ---------------------------------------------------------------- scan + shadow next state
   always_comb begin
      tick      = (pcnt_q == PCNT_LAST);
      frame_end = tick && (idx_q == IDX_LAST);

      pcnt_d = tick ? '0 : pcnt_q + 1'b1;

      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pending_d    = pending_q;

      // The boundary transfer reads the current shadow. A load in the same cycle then
      // overwrites the shadow and keeps pending set, so the displayed copy is always one
      // complete earlier value.
      if (frame_end && pending_q) begin
         disp_val_d = shadow_val_q;
         disp_dp_d  = shadow_dp_q;
         pending_d  = 1'b0;
      end
      if (load) begin
         shadow_val_d = value;
         shadow_dp_d  = dp_in;
         pending_d    = 1'b1;
      end
   end

   // ---------------------------------------------------------------- digit select + blanking
   logic [3:0]          nib_sel;
   logic                dp_sel;
   logic                zero_sel;
   logic [N_DIGITS-1:0] an_hot;
   logic [N_DIGITS-1:0] zero_from;
   logic                lz_run;

   always_comb begin
      // zero_from[i] is set when nibbles i..N_DIGITS-1 of the display register are all zero.
      zero_from = '0;
      lz_run    = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         lz_run       = lz_run && (disp_val_q[4*i +: 4] == 4'h0);
         zero_from[i] = lz_run;
      end

      nib_sel  = 4'h0;
      dp_sel   = 1'b0;
      zero_sel = 1'b0;
      an_hot   = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_sel   = disp_val_q[4*i +: 4];
            dp_sel    = disp_dp_q[i];
            zero_sel  = zero_from[i];
            an_hot[i] = 1'b1;
         end
      end
   end

   seg_t seg_hex;

   seg7_hex_lut u_lut (
      .nibble_i (nib_sel),
      .seg_o    (seg_hex)
   );

   // Digit 0 is never blanked, so a zero value still shows a single '0'.
   logic blank_digit;
   assign blank_digit = blank_lz && (idx_q != '0) && zero_sel;

   always_comb begin
      if (blank_digit) begin
         seg_d = SEG_PIN_OFF;
         dp_d  = SEG_INV;
         an_d  = AN_MASK;
      end else begin
         seg_d = seg_hex ^ SEG_MASK;
         dp_d  = dp_sel ^ SEG_INV;
         an_d  = an_hot ^ AN_MASK;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q       <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_PIN_OFF;
         dp_q         <= SEG_INV;
         an_q         <= AN_MASK;
      end else begin
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
      end
   end

   assign seg     = seg_q;
   assign dp      = dp_q;
   assign an      = an_q;
   assign pending = pending_q;

endmodule
